// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode/control definitions for the 16-bit MIPS core.
// Widths, opcode field, fetch FSM encodings and opcode constants.
package instr_fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_LW  = 4'd8,
        OP_SW  = 4'd10,
        OP_BNE = 4'd14,
        OP_JMP = 4'd15
    } opcode_e;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] a);
        return a + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem req/ack, redirect input, decode valid/ready.
// master = fetch unit side, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [3:0]         opcode;
    logic [PC_W-1:0]    pc_plus1;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr, instr_pc, opcode, pc_plus1
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr, instr_pc, opcode, pc_plus1
    );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: async reset to RESET_PC, redirect load, +1 with wrap.
// Ports: clk, reset_n, inc, load, load_pc -> pc. load beats inc.
module instr_fetch_unit_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc_next(pc);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack, instruction register, redirect squash.
// Ports: clk, reset_n, bus (instr_fetch_unit_if.master).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_fetch_unit_if.master    bus
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic               pc_inc;
    logic               pc_load;
    logic               cap;
    logic               drop;
    logic               hold_addr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    flush_addr;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic               valid_q;

    instr_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_pc (bus.redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        cap       = 1'b0;
        drop      = 1'b0;
        hold_addr = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_load = 1'b1;
                    // Unacked request stays outstanding at the old address.
                    if (!bus.imem_ack) begin
                        hold_addr = 1'b1;
                        state_nxt = FLUSH;
                    end
                end else if (bus.imem_ack) begin
                    cap       = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_load   = 1'b1;
                    drop      = 1'b1;
                    state_nxt = FETCH;
                end else if (bus.instr_ready) begin
                    drop      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                if (bus.redirect_valid) begin
                    pc_load = 1'b1;
                end
                if (bus.imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_addr <= '0;
        end else if (hold_addr) begin
            flush_addr <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else if (cap) begin
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
        end else if (drop) begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.imem_req    = (state == FETCH) || (state == FLUSH);
    assign bus.imem_addr   = (state == FLUSH) ? flush_addr : pc;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.opcode      = get_opcode(instr_q);
    assign bus.pc_plus1    = pc_next(instr_pc_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: handshakes, stalls, redirects,
// PC wrap (second instance at RESET_PC=FFFF) and async reset.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if b1 ();
    instr_fetch_unit_if b2 ();

    instr_fetch_unit #(.RESET_PC(16'h0000)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1.master)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b2.master)
    );

    // Memory image: opcode nibble = addr[3:0] + 2, low bits 12'h123.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [3:0] op;
        op = a[3:0] + 4'h2;
        return {op, 12'h123};
    endfunction

    always_comb b1.imem_rdata = mem_word(b1.imem_addr);
    always_comb b2.imem_rdata = mem_word(b2.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] e2;
        reset_n           = 1'b0;
        b1.imem_ack       = 1'b1;
        b1.instr_ready    = 1'b1;
        b1.redirect_valid = 1'b0;
        b1.redirect_pc    = '0;
        b2.imem_ack       = 1'b1;
        b2.instr_ready    = 1'b1;
        b2.redirect_valid = 1'b0;
        b2.redirect_pc    = '0;

        repeat (2) cyc();
        chk("rst_req", 32'(b1.imem_req), 32'd0);
        chk("rst_valid", 32'(b1.instr_valid), 32'd0);
        chk("rst_instr", 32'(b1.instr), 32'd0);
        chk("rst_ipc", 32'(b1.instr_pc), 32'd0);
        chk("rst_addr", 32'(b1.imem_addr), 32'd0);
        chk("rst_addr2", 32'(b2.imem_addr), 32'hFFFF);
        reset_n = 1'b1;

        // Back-to-back fetch 0..3, valid every second cycle.
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("a_req", 32'(b1.imem_req), 32'd1);
            chk("a_addr", 32'(b1.imem_addr), 32'(i));
            chk("a_vlo", 32'(b1.instr_valid), 32'd0);
            if (i < 2) begin
                e2 = 16'hFFFF + 16'(i);
                chk("wrap_addr", 32'(b2.imem_addr), 32'(e2));
            end
            cyc();
            chk("a_vhi", 32'(b1.instr_valid), 32'd1);
            chk("a_ipc", 32'(b1.instr_pc), 32'(i));
            chk("a_instr", 32'(b1.instr), 32'(mem_word(16'(i))));
            chk("a_opc", 32'(b1.opcode), 32'(i + 2));
            chk("a_pcp1", 32'(b1.pc_plus1), 32'(i + 1));
            chk("a_reqlo", 32'(b1.imem_req), 32'd0);
            if (i == 0) begin
                chk("wrap_ipc", 32'(b2.instr_pc), 32'hFFFF);
                chk("wrap_pcp1", 32'(b2.pc_plus1), 32'h0000);
            end
        end

        // Delayed ack: request at 4 held steady.
        b1.imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("d_req", 32'(b1.imem_req), 32'd1);
            chk("d_addr", 32'(b1.imem_addr), 32'd4);
            chk("d_vlo", 32'(b1.instr_valid), 32'd0);
        end
        cyc();
        chk("d_addr4", 32'(b1.imem_addr), 32'd4);
        b1.imem_ack = 1'b1;
        cyc();
        chk("d_vhi", 32'(b1.instr_valid), 32'd1);
        chk("d_ipc", 32'(b1.instr_pc), 32'd4);
        chk("d_opc", 32'(b1.opcode), 32'd6);

        // Decode stall for 5 cycles.
        b1.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("s_valid", 32'(b1.instr_valid), 32'd1);
            chk("s_ipc", 32'(b1.instr_pc), 32'd4);
            chk("s_instr", 32'(b1.instr), 32'(mem_word(16'd4)));
            chk("s_req", 32'(b1.imem_req), 32'd0);
        end
        b1.instr_ready = 1'b1;
        b1.imem_ack    = 1'b0;
        cyc();
        chk("s_resume", 32'(b1.imem_addr), 32'd5);
        chk("s_rreq", 32'(b1.imem_req), 32'd1);

        // Redirect without ack: FLUSH keeps address 5.
        b1.redirect_valid = 1'b1;
        b1.redirect_pc    = 16'h0040;
        cyc();
        b1.redirect_valid = 1'b0;
        chk("f_req", 32'(b1.imem_req), 32'd1);
        chk("f_addr", 32'(b1.imem_addr), 32'd5);
        cyc();
        chk("f_addr2", 32'(b1.imem_addr), 32'd5);
        chk("f_vlo", 32'(b1.instr_valid), 32'd0);
        b1.imem_ack = 1'b1;
        cyc();
        chk("f_new", 32'(b1.imem_addr), 32'h40);
        chk("f_vlo2", 32'(b1.instr_valid), 32'd0);

        // Redirect coinciding with ack.
        b1.redirect_valid = 1'b1;
        b1.redirect_pc    = 16'h0080;
        cyc();
        b1.redirect_valid = 1'b0;
        chk("c_addr", 32'(b1.imem_addr), 32'h80);
        chk("c_req", 32'(b1.imem_req), 32'd1);
        chk("c_vlo", 32'(b1.instr_valid), 32'd0);
        cyc();
        chk("c_vhi", 32'(b1.instr_valid), 32'd1);
        chk("c_ipc", 32'(b1.instr_pc), 32'h80);

        // Redirect in HOLD with ready high: held instr dropped.
        b1.redirect_valid = 1'b1;
        b1.redirect_pc    = 16'h0100;
        b1.imem_ack       = 1'b0;
        cyc();
        b1.redirect_valid = 1'b0;
        chk("h_vlo", 32'(b1.instr_valid), 32'd0);
        chk("h_addr", 32'(b1.imem_addr), 32'h100);
        chk("h_req", 32'(b1.imem_req), 32'd1);

        // Async reset in FETCH.
        #2 reset_n = 1'b0;
        #1;
        chk("r_req", 32'(b1.imem_req), 32'd0);
        chk("r_valid", 32'(b1.instr_valid), 32'd0);
        chk("r_addr", 32'(b1.imem_addr), 32'd0);
        cyc();
        reset_n     = 1'b1;
        b1.imem_ack = 1'b1;
        b1.instr_ready = 1'b0;
        cyc();
        chk("r_restart", 32'(b1.imem_addr), 32'd0);
        chk("r_rreq", 32'(b1.imem_req), 32'd1);
        cyc();
        chk("r_vhi", 32'(b1.instr_valid), 32'd1);

        // Async reset in HOLD drops valid.
        #2 reset_n = 1'b0;
        #1;
        chk("r2_valid", 32'(b1.instr_valid), 32'd0);
        chk("r2_instr", 32'(b1.instr), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
